// File: rtl/gui_frame_sequencer.sv
// Frame-locked image sequencer: shows each image ROM for a fixed number of OLED
// frames, separated by background-only frames, with start/stop/skip/loop control.
module gui_frame_sequencer #(
  parameter int          NUM_IMG      = 4,
  parameter int          HOLD_FRAMES  = 30,
  parameter int          BLANK_FRAMES = 4,
  parameter logic [15:0] BG_COLOUR    = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_begin,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   skip,
  input  logic                   loop_en,
  input  logic [16*NUM_IMG-1:0]  rom_colour,
  output logic [2:0]             img_sel,
  output logic [15:0]            oled_colour,
  output logic                   busy,
  output logic                   done
);

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] BLANK_LAST = (BLANK_FRAMES == 0) ? 8'd0 : 8'(BLANK_FRAMES - 1);
  localparam logic [2:0] LAST_IMG   = 3'(NUM_IMG - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [2:0]  img_sel_reg, img_sel_next;
  logic        start_pend_reg, start_pend_next;
  logic        skip_reg, skip_next;
  logic        done_reg, done_next;
  logic [15:0] oled_colour_reg, oled_colour_next;

  state_t      adv_state;
  logic [2:0]  adv_img;
  logic        adv_done;
  logic [15:0] rom_slice [8];

  // Unpack to a full 8-entry table so any img_sel value indexes safely.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slice
      if (gi < NUM_IMG) begin : g_rom
        assign rom_slice[gi] = rom_colour[16*gi +: 16];
      end else begin : g_bg
        assign rom_slice[gi] = BG_COLOUR;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 8'd0;
      img_sel_reg     <= 3'd0;
      start_pend_reg  <= 1'b0;
      skip_reg        <= 1'b0;
      done_reg        <= 1'b0;
      oled_colour_reg <= BG_COLOUR;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      img_sel_reg     <= img_sel_next;
      start_pend_reg  <= start_pend_next;
      skip_reg        <= skip_next;
      done_reg        <= done_next;
      oled_colour_reg <= oled_colour_next;
    end
  end

  // Where the sequence goes once an image (and its blanking) has finished.
  always_comb begin
    adv_state = SHOW;
    adv_img   = img_sel_reg + 3'd1;
    adv_done  = 1'b0;
    if (img_sel_reg >= LAST_IMG) begin
      adv_img = 3'd0;
      if (!loop_en) begin
        adv_state = IDLE;
        adv_done  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    img_sel_next    = img_sel_reg;
    start_pend_next = start_pend_reg;
    skip_next       = skip_reg;
    done_next       = 1'b0;

    if (stop) begin
      state_next      = IDLE;
      cnt_next        = 8'd0;
      img_sel_next    = 3'd0;
      start_pend_next = 1'b0;
      skip_next       = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) start_pend_next = 1'b1;
          if (frame_begin && (start_pend_reg || start)) begin
            state_next      = SHOW;
            img_sel_next    = 3'd0;
            cnt_next        = 8'd0;
            start_pend_next = 1'b0;
          end
        end
        SHOW: begin
          if (skip) skip_next = 1'b1;
          if (frame_begin) begin
            if (skip_reg || skip || cnt_reg == HOLD_LAST) begin
              cnt_next  = 8'd0;
              skip_next = 1'b0;
              if (BLANK_FRAMES == 0) begin
                state_next   = adv_state;
                img_sel_next = adv_img;
                done_next    = adv_done;
              end else begin
                state_next = BLANK;
              end
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end
        end
        BLANK: begin
          if (frame_begin) begin
            if (cnt_reg == BLANK_LAST) begin
              cnt_next     = 8'd0;
              state_next   = adv_state;
              img_sel_next = adv_img;
              done_next    = adv_done;
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    oled_colour_next = BG_COLOUR;
    if (state_reg == SHOW && rom_slice[img_sel_reg] != BG_COLOUR)
      oled_colour_next = rom_slice[img_sel_reg];
  end

  assign img_sel     = img_sel_reg;
  assign oled_colour = oled_colour_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

endmodule

// File: tb/tb_gui_frame_sequencer.sv
// Bench for gui_frame_sequencer with 3 images, 3 hold frames, 1 blank frame,
// frame_begin roughly every 100 cycles.
module tb_gui_frame_sequencer;

  localparam logic [15:0] BG = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_begin = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        skip = 1'b0;
  logic        loop_en = 1'b0;
  logic [47:0] rom_colour;
  logic [2:0]  img_sel;
  logic [15:0] oled_colour;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] img;
    logic       busy;
    logic       done;
    logic       show;
  } vec_t;

  vec_t        seq_tab [13];
  vec_t        loop_tab [11];
  vec_t        exp_q [$];
  logic [15:0] colours [3];

  gui_frame_sequencer #(
    .NUM_IMG(3), .HOLD_FRAMES(3), .BLANK_FRAMES(1), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .start(start),
    .stop(stop), .skip(skip), .loop_en(loop_en), .rom_colour(rom_colour),
    .img_sel(img_sel), .oled_colour(oled_colour), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk) frame_begin = 1'b1;
    @(negedge clk) frame_begin = 1'b0;
  endtask

  task automatic pulse_ctrl(input logic s_start, input logic s_stop, input logic s_skip);
    @(negedge clk);
    start = s_start; stop = s_stop; skip = s_skip;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; skip = 1'b0;
  endtask

  // One frame: expectation queued at drive, popped and compared after the edge.
  task automatic apply_vec(input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    pulse_frame();
    e = exp_q.pop_front();
    check("img_sel", 16'(img_sel), 16'(e.img));
    check("busy", 16'(busy), 16'(e.busy));
    check("done", 16'(done), 16'(e.done));
    @(negedge clk);
    check("oled", oled_colour, e.show ? colours[e.img] : BG);
    check("done_1cyc", 16'(done), 16'd0);
    repeat (95) @(negedge clk);
  endtask

  initial begin
    colours[0] = 16'h1111; colours[1] = 16'h2222; colours[2] = 16'h3333;
    rom_colour = {colours[2], colours[1], colours[0]};

    seq_tab = '{
      '{3'd0,1'b1,1'b0,1'b1}, '{3'd0,1'b1,1'b0,1'b1}, '{3'd0,1'b1,1'b0,1'b1}, '{3'd0,1'b1,1'b0,1'b0},
      '{3'd1,1'b1,1'b0,1'b1}, '{3'd1,1'b1,1'b0,1'b1}, '{3'd1,1'b1,1'b0,1'b1}, '{3'd1,1'b1,1'b0,1'b0},
      '{3'd2,1'b1,1'b0,1'b1}, '{3'd2,1'b1,1'b0,1'b1}, '{3'd2,1'b1,1'b0,1'b1}, '{3'd2,1'b1,1'b0,1'b0},
      '{3'd0,1'b0,1'b1,1'b0}};
    // Entry 0 is followed by a skip, so image 0 is cut to one frame.
    loop_tab = '{
      '{3'd0,1'b1,1'b0,1'b1}, '{3'd0,1'b1,1'b0,1'b0},
      '{3'd1,1'b1,1'b0,1'b1}, '{3'd1,1'b1,1'b0,1'b1}, '{3'd1,1'b1,1'b0,1'b1}, '{3'd1,1'b1,1'b0,1'b0},
      '{3'd2,1'b1,1'b0,1'b1}, '{3'd2,1'b1,1'b0,1'b1}, '{3'd2,1'b1,1'b0,1'b1}, '{3'd2,1'b1,1'b0,1'b0},
      '{3'd0,1'b1,1'b0,1'b1}};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_img_sel", 16'(img_sel), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_oled", oled_colour, BG);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Non-looping run: start is pending until the next frame_begin
    pulse_ctrl(1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("pending_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 13; i++) apply_vec(seq_tab[i]);

    // Looping run with skip in frame 0 of image 0 and a colour-key test
    loop_en = 1'b1;
    pulse_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i == 1) pulse_ctrl(1'b0, 1'b0, 1'b1);
      apply_vec(loop_tab[i]);
      if (i == 2) begin
        @(negedge clk) rom_colour = {16'h0000, 16'hF800, 16'h0000};
        @(negedge clk);
        check("key_red", oled_colour, 16'hF800);
        rom_colour = {16'h0000, 16'h0000, 16'h0000};
        @(negedge clk);
        check("key_bg", oled_colour, BG);
        rom_colour = {colours[2], colours[1], colours[0]};
      end
    end

    // stop and start together mid-SHOW: stop wins, no pending start survives
    pulse_ctrl(1'b1, 1'b1, 1'b0);
    check("stop_busy", 16'(busy), 16'd0);
    check("stop_done", 16'(done), 16'd0);
    check("stop_img_sel", 16'(img_sel), 16'd0);
    pulse_frame();
    check("stop_stays_idle", 16'(busy), 16'd0);
    repeat (50) @(negedge clk);

    // Reset during BLANK of image 1, then require a fresh start
    loop_en = 1'b0;
    pulse_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply_vec(seq_tab[i]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_img_sel", 16'(img_sel), 16'd0);
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_done", 16'(done), 16'd0);
    check("arst_oled", oled_colour, BG);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulse_frame();
    check("post_rst_idle", 16'(busy), 16'd0);
    check("post_rst_img", 16'(img_sel), 16'd0);
    repeat (50) @(negedge clk);
    pulse_ctrl(1'b1, 1'b0, 1'b0);
    apply_vec(seq_tab[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gui_frame_sequencer.md
GUI_FRAME_SEQUENCER -- requirements
Module: gui_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_IMG, default 4: number of image ROMs sequenced (2..8).
REQ-002 SHALL have parameter HOLD_FRAMES, default 30: display frames each image is shown (1..255).
REQ-003 SHALL have parameter BLANK_FRAMES, default 4: background-only frames between images (0..255).
REQ-004 SHALL have parameter BG_COLOUR, default 16'h0000: RGB565 background and transparent-key colour.
REQ-005 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port frame_begin, input, 1: one-cycle pulse at start of each OLED frame.
REQ-008 SHALL have port start, input, 1: one-cycle pulse to begin the sequence.
REQ-009 SHALL have port stop, input, 1: one-cycle pulse to abort to idle.
REQ-010 SHALL have port skip, input, 1: one-cycle pulse to end the current image early.
REQ-011 SHALL have port loop_en, input, 1: level; 1 = wrap to image 0 after the last image.
REQ-012 SHALL have port rom_colour, input, 16*NUM_IMG: packed combinational ROM outputs; image k at bits [16k+15:16k].
REQ-013 SHALL have port img_sel, output, 3: index of the image currently shown.
REQ-014 SHALL have port oled_colour, output, 16: registered pixel colour to the OLED driver.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a non-looping sequence completes.

Function
REQ-017 SHALL implement FSM states IDLE, SHOW, BLANK.
REQ-018 IDLE: start -> SHOW at the next frame_begin; img_sel=0, hold count=0; a start pulse is latched as pending until that frame_begin.
REQ-019 SHOW: each frame_begin increments the hold count; on the frame_begin where the count equals HOLD_FRAMES-1 -> BLANK, count cleared.
REQ-020 skip in SHOW SHALL be latched; the next frame_begin -> BLANK regardless of hold count; the latch then clears.
REQ-021 BLANK: each frame_begin increments the count; on the frame_begin where the count equals BLANK_FRAMES-1 (or immediately if BLANK_FRAMES=0) advance the image.
REQ-022 Advance: if img_sel < NUM_IMG-1 then img_sel+1, -> SHOW.
REQ-023 Advance at the last image: loop_en=1 -> img_sel=0, SHOW; loop_en=0 -> IDLE, done pulses for exactly one cycle.
REQ-024 BLANK_FRAMES=0 SHALL skip BLANK entirely: SHOW goes straight to advance on the same frame_begin.
REQ-025 img_sel and state SHALL change only on frame_begin cycles, so a frame never tears; exception: stop.
REQ-026 stop SHALL force IDLE on the next clock from any state, clear counters, pending start and skip latch, with no done pulse.
REQ-027 stop and start asserted in the same cycle: stop wins; the sequencer ends in IDLE with no pending start.
REQ-028 start while busy SHALL be ignored.
REQ-029 oled_colour SHALL be registered with 1-cycle latency from rom_colour.
REQ-030 In SHOW, oled_colour SHALL be rom_colour slice img_sel when it differs from BG_COLOUR, else BG_COLOUR.
REQ-031 In IDLE and BLANK, oled_colour SHALL be BG_COLOUR.
REQ-032 Counters SHALL be 8 bits and SHALL never wrap: compare-and-clear bounds them.

Reset
REQ-033 While rst_n=0: state IDLE, img_sel=0, counters 0, latches 0, oled_colour=BG_COLOUR, busy=0, done=0.
REQ-034 rst_n deassertion mid-sequence SHALL resume from IDLE and require a new start.

Verification (NUM_IMG=3, HOLD_FRAMES=3, BLANK_FRAMES=1, frame_begin every 100 cycles)
REQ-035 Start, loop_en=0 -> img_sel 0,1,2 each for 3 frames with 1 BG frame between; done pulses once at the frame_begin ending the last BLANK; busy drops the same cycle.
REQ-036 rom_colour slice 1 = 16'hF800, others 16'h0000, img_sel=1 -> oled_colour = 16'hF800 one cycle after the input is applied; slice 1 = 16'h0000 -> oled_colour=BG_COLOUR.
REQ-037 skip in frame 0 of image 0 -> BLANK at the next frame_begin; image 1 starts one frame later.
REQ-038 loop_en=1 -> after image 2, img_sel returns to 0; done never asserts.
REQ-039 stop and start in the same cycle mid-SHOW -> IDLE next clock, busy=0, done=0; the next frame_begin leaves the sequencer in IDLE.
REQ-040 rst_n low for 3 cycles during BLANK of image 1 -> all outputs equal reset values asynchronously; stays IDLE until a new start.
